// File: rtl/shift_seq_tx_pkg.sv
// Shared definitions for the shift-sequence transmitter: state encodings and default sizes.
package shift_seq_tx_pkg;

  localparam int N_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_PAR  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_tx_piso_shifter.sv
// N-bit parallel-load, MSB-first shift register.
// head is the bit at the MSB after this cycle's shift (q[N-2] when shifting, q[N-1] otherwise).
module piso_shifter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sh,
  input  logic [N-1:0] din,
  output logic         head
);

  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign q_next[gi] = ld ? din[gi] : (sh ? 1'b0 : q_reg[gi]);
      end else begin : g_upper
        assign q_next[gi] = ld ? din[gi] : (sh ? q_reg[gi-1] : q_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_reg <= '0;
    else     q_reg <= q_next;
  end

  assign head = sh ? q_reg[N-2] : q_reg[N-1];

endmodule

// File: rtl/shift_seq_tx.sv
// Serial sequence transmitter: shifts a sync code then a data word out MSB-first on outbit.
// Define SHIFT_SEQ_PARITY_EN to append an even-parity bit over the data word.
module shift_seq_tx
  import shift_seq_tx_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] code,
  input  logic [N-1:0] data,
  output logic         outbit,
  output logic         busy,
  output logic         done
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             outbit_reg, outbit_next;
  logic             done_reg, done_next;
  logic             cap, code_sh, data_sh;
  logic             code_head, data_head;
  logic             cnt_zero;

`ifdef SHIFT_SEQ_PARITY_EN
  logic             par_reg;
`endif

  piso_shifter #(.N(N)) u_code (
    .clk(clk), .rst(rst), .ld(cap), .sh(code_sh), .din(code), .head(code_head)
  );

  piso_shifter #(.N(N)) u_data (
    .clk(clk), .rst(rst), .ld(cap), .sh(data_sh), .din(data), .head(data_head)
  );

  assign cnt_zero = (cnt_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      outbit_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      outbit_reg <= outbit_next;
      done_reg   <= done_next;
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  // Parity is taken at capture time because the data shifter is consumed during the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      par_reg <= 1'b0;
    else if (cap) par_reg <= ^data;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (load) state_next = ST_SYNC;
      ST_SYNC: if (cnt_zero) state_next = ST_DATA;
      ST_DATA: begin
        if (cnt_zero) begin
`ifdef SHIFT_SEQ_PARITY_EN
          state_next = ST_PAR;
`else
          state_next = ST_IDLE;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_next    = cnt_reg;
    outbit_next = 1'b0;
    done_next   = 1'b0;
    cap         = 1'b0;
    code_sh     = 1'b0;
    data_sh     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          cap         = 1'b1;
          outbit_next = code[N-1];
          cnt_next    = CNT_W'(N-1);
        end
      end
      ST_SYNC: begin
        if (!cnt_zero) begin
          code_sh     = 1'b1;
          outbit_next = code_head;
          cnt_next    = cnt_reg - CNT_W'(1);
        end else begin
          outbit_next = data_head;
          cnt_next    = CNT_W'(N-1);
        end
      end
      ST_DATA: begin
        if (!cnt_zero) begin
          data_sh     = 1'b1;
          outbit_next = data_head;
          cnt_next    = cnt_reg - CNT_W'(1);
        end else begin
`ifdef SHIFT_SEQ_PARITY_EN
          outbit_next = par_reg;
`else
          done_next   = 1'b1;
`endif
        end
      end
      default: done_next = 1'b1;
    endcase
  end

  assign busy   = (state_reg != ST_IDLE);
  assign outbit = outbit_reg;
  assign done   = done_reg;

endmodule
